gp_timer: RTL and testbench
===========================

GP_TIMER -- requirements
Module: gp_timer

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 5, meaning the byte-offset width decoded within the peripheral window.
REQ-002 SHALL have parameter RESET_COMPARE, default 32'hFFFF_FFFF, meaning the COMPARE register reset value.
REQ-003 SHALL have ports:
- clk  input  1  global system clock.
- rst_n  input  1  reset; asynchronous, active-low.
- rd_en  input  1  read request from the core's AXI port.
- wr_en  input  1  write request.
- addr  input  ADDR_WIDTH  byte offset; addr[1:0] ignored.
- wr_data  input  32  write data.
- wr_strobe  input  4  byte-lane write enables.
- rd_data  output  32  read data.
- access_fault  output  1  bus error response.
- busy  output  1  wait request; the initiator holds its request while high.
- interrupt  output  1  level interrupt, drives timer0_int/timer1_int.

Function
REQ-004 SHALL implement a register map: 0x00 CTRL (bit0 EN, bit1 IE, bit2 ONESHOT, other bits read 0); 0x04 PRESCALE; 0x08 VALUE; 0x0C COMPARE; 0x10 STATUS (bit0 MATCH, write-1-to-clear).
REQ-005 SHALL treat offsets 0x14-0x1C, and rd_en together with wr_en, as faults with no register side effects.
REQ-006 SHALL complete writes with zero wait states: busy=0, and a byte lane updates at the clock edge when its wr_strobe bit is set.
REQ-007 SHALL assert access_fault combinationally in the same cycle as a faulting write.
REQ-008 SHALL complete reads with exactly one wait state, through states IDLE and DATA.
- IDLE with rd_en: busy=1; the register is sampled at the edge; go to DATA.
- DATA: busy=0; rd_data and access_fault are valid; go to IDLE.
REQ-009 SHALL go from DATA to IDLE unconditionally; a rd_en still high in DATA is that request's completion cycle, not a new request.
REQ-010 SHALL drive rd_data=0 whenever not in DATA, and also in DATA when the read faulted.
REQ-011 SHALL keep access_fault=0 except as defined in REQ-007 and in DATA for a faulting read.
REQ-012 SHALL run an internal 32-bit prescale counter while EN=1: a tick occurs when the counter equals PRESCALE, then the counter resets to 0; PRESCALE=0 ticks every cycle.
REQ-013 SHALL handle each tick as follows:
- VALUE==COMPARE: VALUE<=0, MATCH<=1, and EN<=0 if ONESHOT=1.
- otherwise: VALUE<=VALUE+1, wrapping modulo 2^32.
REQ-014 SHALL clear the prescale counter and hold VALUE while EN=0.
REQ-015 SHALL let a software write to VALUE take priority over a same-cycle tick update.
REQ-016 SHALL let a hardware MATCH set take priority over a same-cycle W1C clear.
REQ-017 SHALL clear the prescale counter on any write to PRESCALE.
REQ-018 SHALL drive interrupt = MATCH & IE from registers, with no combinational path from the bus inputs.

Reset
REQ-019 SHALL, on rst_n low at any time, asynchronously reset: CTRL=0, PRESCALE=0, VALUE=0, COMPARE=RESET_COMPARE, MATCH=0, prescale counter=0, state=IDLE.
REQ-020 SHALL hold rd_data=0, busy=0, access_fault=0, interrupt=0 while rst_n is low.
REQ-021 SHALL abandon a read pending at reset; no DATA cycle follows reset release.

Verification
REQ-022 SHALL cover a basic read: after reset, rd_en at 0x0C -> busy=1 for one cycle, then rd_data=32'hFFFF_FFFF with busy=0 and access_fault=0.
REQ-023 SHALL cover periodic counting: PRESCALE=1, COMPARE=3, CTRL=3 -> VALUE increments every 2 cycles through 0,1,2,3,0; MATCH and interrupt rise on the wrap and stay high until 1 is written to STATUS bit0.
REQ-024 SHALL cover one-shot mode: CTRL=5, COMPARE=0, PRESCALE=0 -> a single tick sets MATCH, clears EN, and VALUE stays 0 thereafter.
REQ-025 SHALL cover faults and strobes:
- wr_en at 0x14 -> access_fault=1 that cycle, no state change.
- wr_strobe=4'b0010 with data 32'hAABBCCDD to COMPARE -> COMPARE=32'hFFFF_CCFF.
REQ-026 SHALL cover simultaneous events:
- a W1C of STATUS in the same cycle as a match -> MATCH remains 1.
- a VALUE write of 7 during a tick -> VALUE=7.
REQ-027 SHALL cover reset mid-read: rst_n low during the busy cycle -> all outputs 0; after release, the next read behaves per REQ-022.

Source files
------------

// File: rtl/gp_timer.sv
// rtl/gp_timer.sv - general purpose 32-bit timer with prescaler, compare match and register bus
module gp_timer #(
  parameter int          ADDR_WIDTH    = 5,
  parameter logic [31:0] RESET_COMPARE = 32'hFFFF_FFFF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rd_en,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wr_data,
  input  logic [3:0]            wr_strobe,
  output logic [31:0]           rd_data,
  output logic                  access_fault,
  output logic                  busy,
  output logic                  interrupt
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_DATA = 1'b1
  } state_e;

  state_e      state_q, state_d;

  logic [2:0]  ctrl_q, ctrl_d;        // {ONESHOT, IE, EN}
  logic [31:0] prescale_q, prescale_d;
  logic [31:0] value_q, value_d;
  logic [31:0] compare_q, compare_d;
  logic        match_q, match_d;
  logic [31:0] pcnt_q, pcnt_d;
  logic [31:0] rd_q, rd_d;
  logic        rd_fault_q, rd_fault_d;

  logic [29:0] word_idx;
  logic        addr_ok;
  logic        sel_ctrl, sel_pre, sel_val, sel_cmp, sel_stat;
  logic        wr_ok, wr_fault;
  logic        busy_c;
  logic        tick, hit;
  logic [31:0] rd_mux;
  logic        unused_addr_bits;

  // Byte offset bits [1:0] carry no information for word-wide registers.
  assign unused_addr_bits = ^addr[1:0];

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_v;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) res[8*i +: 8] = new_v[8*i +: 8];
    end
    return res;
  endfunction

  // Address decode; anything past STATUS is a hole in the window.
  always_comb begin
    word_idx = 30'(addr[ADDR_WIDTH-1:2]);
    addr_ok  = (word_idx <= 30'd4);
    sel_ctrl = (word_idx == 30'd0);
    sel_pre  = (word_idx == 30'd1);
    sel_val  = (word_idx == 30'd2);
    sel_cmp  = (word_idx == 30'd3);
    sel_stat = (word_idx == 30'd4);
  end

  // A write with a simultaneous read is ambiguous, so it faults and is dropped.
  assign wr_ok    = wr_en & ~rd_en & addr_ok;
  assign wr_fault = wr_en & (rd_en | ~addr_ok);

  // Read mux of current register contents, sampled on the request edge.
  always_comb begin
    rd_mux = 32'd0;
    case (1'b1)
      sel_ctrl: rd_mux = {29'd0, ctrl_q};
      sel_pre:  rd_mux = prescale_q;
      sel_val:  rd_mux = value_q;
      sel_cmp:  rd_mux = compare_q;
      sel_stat: rd_mux = {31'd0, match_q};
      default:  rd_mux = 32'd0;
    endcase
  end

  // Read handshake: one wait state in IDLE, then a single DATA cycle.
  always_comb begin
    state_d    = state_q;
    busy_c     = 1'b0;
    rd_d       = rd_q;
    rd_fault_d = rd_fault_q;
    case (state_q)
      S_IDLE: begin
        if (rd_en) begin
          busy_c     = 1'b1;
          rd_d       = rd_mux;
          rd_fault_d = ~addr_ok | wr_en;
          state_d    = S_DATA;
        end
      end
      S_DATA: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Bus outputs are forced quiet while reset is asserted.
  always_comb begin
    busy         = rst_n & busy_c;
    access_fault = rst_n & (wr_fault | ((state_q == S_DATA) & rd_fault_q));
    rd_data      = ((state_q == S_DATA) && !rd_fault_q) ? rd_q : 32'd0;
    interrupt    = match_q & ctrl_q[1];
  end

  // Timer next state: prescaler, counter, match flag and software writes.
  always_comb begin
    ctrl_d     = ctrl_q;
    prescale_d = prescale_q;
    value_d    = value_q;
    compare_d  = compare_q;
    match_d    = match_q;
    pcnt_d     = pcnt_q + 32'd1;

    tick = ctrl_q[0] & (pcnt_q == prescale_q);
    hit  = (value_q == compare_q);

    if (!ctrl_q[0] || tick || (wr_ok && sel_pre)) pcnt_d = 32'd0;

    // Counter: software write beats the tick update in the same cycle.
    if (wr_ok && sel_val)  value_d = merge_bytes(value_q, wr_data, wr_strobe);
    else if (tick)         value_d = hit ? 32'd0 : value_q + 32'd1;

    // One-shot self-disable; an explicit CTRL write in the same cycle wins.
    if (tick && hit && ctrl_q[2]) ctrl_d[0] = 1'b0;
    if (wr_ok && sel_ctrl && wr_strobe[0]) ctrl_d = wr_data[2:0];

    if (wr_ok && sel_pre) prescale_d = merge_bytes(prescale_q, wr_data, wr_strobe);
    if (wr_ok && sel_cmp) compare_d  = merge_bytes(compare_q, wr_data, wr_strobe);

    // W1C first, so a simultaneous hardware match set overrides it.
    if (wr_ok && sel_stat && wr_strobe[0] && wr_data[0]) match_d = 1'b0;
    if (tick && hit) match_d = 1'b1;
  end

  // State registers with asynchronous reset; a pending read is abandoned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      ctrl_q     <= 3'd0;
      prescale_q <= 32'd0;
      value_q    <= 32'd0;
      compare_q  <= RESET_COMPARE;
      match_q    <= 1'b0;
      pcnt_q     <= 32'd0;
      rd_q       <= 32'd0;
      rd_fault_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ctrl_q     <= ctrl_d;
      prescale_q <= prescale_d;
      value_q    <= value_d;
      compare_q  <= compare_d;
      match_q    <= match_d;
      pcnt_q     <= pcnt_d;
      rd_q       <= rd_d;
      rd_fault_q <= rd_fault_d;
    end
  end

endmodule

// File: tb/tb_gp_timer.sv
// tb/tb_gp_timer.sv - self-checking bench for gp_timer
module tb_gp_timer;

  localparam logic [4:0] A_CTRL = 5'h00;
  localparam logic [4:0] A_PRE  = 5'h04;
  localparam logic [4:0] A_VAL  = 5'h08;
  localparam logic [4:0] A_CMP  = 5'h0C;
  localparam logic [4:0] A_STAT = 5'h10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rd_en = 1'b0;
  logic        wr_en = 1'b0;
  logic [4:0]  addr = 5'd0;
  logic [31:0] wr_data = 32'd0;
  logic [3:0]  wr_strobe = 4'd0;
  logic [31:0] rd_data;
  logic        access_fault;
  logic        busy;
  logic        interrupt;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] r_d, r_d0;
  logic        r_f, r_b0, r_b1, w_f;

  gp_timer #(.ADDR_WIDTH(5), .RESET_COMPARE(32'hFFFF_FFFF)) dut (
    .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .wr_en(wr_en), .addr(addr),
    .wr_data(wr_data), .wr_strobe(wr_strobe), .rd_data(rd_data),
    .access_fault(access_fault), .busy(busy), .interrupt(interrupt)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // One-cycle write; f is access_fault seen before the edge.
  task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s, output logic f);
    addr = a; wr_data = d; wr_strobe = s; wr_en = 1'b1;
    #1 f = access_fault;
    @(posedge clk); #1;
    wr_en = 1'b0; wr_strobe = 4'd0;
  endtask

  // Two-cycle read: b0/d0 in the wait cycle, b1/d/f in the data cycle.
  task automatic rd(input logic [4:0] a, output logic [31:0] d, output logic f,
                    output logic b0, output logic b1, output logic [31:0] d0);
    addr = a; rd_en = 1'b1;
    #1 b0 = busy; d0 = rd_data;
    @(posedge clk); #1;
    b1 = busy; d = rd_data; f = access_fault;
    rd_en = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    logic [31:0] exp_regs [5];
    logic [4:0]  addrs [5];
    exp_regs = '{32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'd0};
    addrs    = '{A_CTRL, A_PRE, A_VAL, A_CMP, A_STAT};
    rd_en = 1'b1; addr = A_CMP;
    repeat (2) @(posedge clk);
    #1;
    n_tests++; if ({busy, access_fault, interrupt} !== 3'b000 || rd_data !== 32'd0) begin
      n_fail++; $display("FAIL reset_outputs: got busy=%b fault=%b int=%b data=%h expected all 0", busy, access_fault, interrupt, rd_data);
    end
    rd_en = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      rd(addrs[i], r_d, r_f, r_b0, r_b1, r_d0);
      n_tests++; if (r_d !== exp_regs[i]) begin
        n_fail++; $display("FAIL reset_reg_%0d: got %h expected %h", i, r_d, exp_regs[i]);
      end
    end
  endtask

  task automatic test_basic_read;
    rd(A_CMP, r_d, r_f, r_b0, r_b1, r_d0);
    n_tests++; if (r_b0 !== 1'b1 || r_d0 !== 32'd0) begin
      n_fail++; $display("FAIL basic_read_wait: got busy=%b data=%h expected busy=1 data=0", r_b0, r_d0);
    end
    n_tests++; if (r_b1 !== 1'b0 || r_f !== 1'b0 || r_d !== 32'hFFFF_FFFF) begin
      n_fail++; $display("FAIL basic_read_data: got busy=%b fault=%b data=%h expected 0 0 ffffffff", r_b1, r_f, r_d);
    end
  endtask

  task automatic test_periodic;
    wr(A_CTRL, 32'd0, 4'hF, w_f);
    wr(A_STAT, 32'd1, 4'hF, w_f);
    wr(A_VAL,  32'd0, 4'hF, w_f);
    wr(A_PRE,  32'd1, 4'hF, w_f);
    wr(A_CMP,  32'd3, 4'hF, w_f);
    wr(A_CTRL, 32'd3, 4'hF, w_f);
    n_tests++; if (w_f !== 1'b0) begin
      n_fail++; $display("FAIL periodic_write_fault: got %b expected 0", w_f);
    end
    for (int i = 0; i < 5; i++) begin
      rd(A_VAL, r_d, r_f, r_b0, r_b1, r_d0);
      n_tests++; if (r_d !== 32'(i % 4)) begin
        n_fail++; $display("FAIL periodic_value_%0d: got %0d expected %0d", i, r_d, i % 4);
      end
      n_tests++; if (interrupt !== (i >= 3)) begin
        n_fail++; $display("FAIL periodic_int_%0d: got %b expected %b", i, interrupt, (i >= 3));
      end
    end
    rd(A_STAT, r_d, r_f, r_b0, r_b1, r_d0);
    n_tests++; if (r_d !== 32'd1) begin
      n_fail++; $display("FAIL periodic_match: got %h expected 1", r_d);
    end
    wr(A_CTRL, 32'd2, 4'hF, w_f);
    n_tests++; if (interrupt !== 1'b1) begin
      n_fail++; $display("FAIL periodic_int_hold: got %b expected 1", interrupt);
    end
    wr(A_STAT, 32'd1, 4'hF, w_f);
    n_tests++; if (interrupt !== 1'b0) begin
      n_fail++; $display("FAIL periodic_int_clear: got %b expected 0", interrupt);
    end
    rd(A_STAT, r_d, r_f, r_b0, r_b1, r_d0);
    n_tests++; if (r_d !== 32'd0) begin
      n_fail++; $display("FAIL periodic_w1c: got %h expected 0", r_d);
    end
  endtask

  task automatic test_oneshot;
    wr(A_CTRL, 32'd0, 4'hF, w_f);
    wr(A_STAT, 32'd1, 4'hF, w_f);
    wr(A_VAL,  32'd0, 4'hF, w_f);
    wr(A_PRE,  32'd0, 4'hF, w_f);
    wr(A_CMP,  32'd0, 4'hF, w_f);
    wr(A_CTRL, 32'd5, 4'hF, w_f);
    repeat (5) @(posedge clk);
    #1;
    rd(A_CTRL, r_d, r_f, r_b0, r_b1, r_d0);
    n_tests++; if (r_d !== 32'd4) begin
      n_fail++; $display("FAIL oneshot_ctrl: got %h expected 4", r_d);
    end
    rd(A_STAT, r_d, r_f, r_b0, r_b1, r_d0);
    n_tests++; if (r_d !== 32'd1) begin
      n_fail++; $display("FAIL oneshot_match: got %h expected 1", r_d);
    end
    rd(A_VAL, r_d, r_f, r_b0, r_b1, r_d0);
    n_tests++; if (r_d !== 32'd0) begin
      n_fail++; $display("FAIL oneshot_value: got %h expected 0", r_d);
    end
  endtask

  task automatic test_fault_strobe;
    logic [31:0] exp_regs [5];
    logic [4:0]  addrs [5];
    exp_regs = '{32'd2, 32'd5, 32'd3, 32'd9, 32'd0};
    addrs    = '{A_CTRL, A_PRE, A_VAL, A_CMP, A_STAT};
    wr(A_CTRL, 32'd0, 4'hF, w_f);
    wr(A_STAT, 32'd1, 4'hF, w_f);
    wr(A_PRE,  32'd5, 4'hF, w_f);
    wr(A_VAL,  32'd3, 4'hF, w_f);
    wr(A_CMP,  32'd9, 4'hF, w_f);
    wr(A_CTRL, 32'd2, 4'hF, w_f);
    wr(5'h14, 32'hFFFF_FFFF, 4'hF, w_f);
    n_tests++; if (w_f !== 1'b1) begin
      n_fail++; $display("FAIL fault_wr_14: got %b expected 1", w_f);
    end
    wr(5'h1C, 32'hFFFF_FFFF, 4'hF, w_f);
    n_tests++; if (w_f !== 1'b1) begin
      n_fail++; $display("FAIL fault_wr_1c: got %b expected 1", w_f);
    end
    // Read and write together at a valid address.
    addr = A_VAL; wr_data = 32'd0; wr_strobe = 4'hF; wr_en = 1'b1; rd_en = 1'b1;
    #1;
    n_tests++; if (busy !== 1'b1 || access_fault !== 1'b1) begin
      n_fail++; $display("FAIL fault_rdwr_first: got busy=%b fault=%b expected 1 1", busy, access_fault);
    end
    @(posedge clk); #1;
    wr_en = 1'b0; wr_strobe = 4'd0;
    n_tests++; if (busy !== 1'b0 || access_fault !== 1'b1 || rd_data !== 32'd0) begin
      n_fail++; $display("FAIL fault_rdwr_data: got busy=%b fault=%b data=%h expected 0 1 0", busy, access_fault, rd_data);
    end
    rd_en = 1'b0;
    @(posedge clk); #1;
    rd(5'h18, r_d, r_f, r_b0, r_b1, r_d0);
    n_tests++; if (r_f !== 1'b1 || r_d !== 32'd0 || r_b0 !== 1'b1 || r_b1 !== 1'b0) begin
      n_fail++; $display("FAIL fault_rd_18: got fault=%b data=%h busy=%b%b expected 1 0 10", r_f, r_d, r_b0, r_b1);
    end
    for (int i = 0; i < 5; i++) begin
      rd(addrs[i], r_d, r_f, r_b0, r_b1, r_d0);
      n_tests++; if (r_d !== exp_regs[i] || r_f !== 1'b0) begin
        n_fail++; $display("FAIL fault_no_effect_%0d: got %h fault=%b expected %h fault=0", i, r_d, r_f, exp_regs[i]);
      end
    end
    wr(A_CMP, 32'hFFFF_FFFF, 4'hF, w_f);
    wr(A_CMP, 32'hAABB_CCDD, 4'b0010, w_f);
    rd(A_CMP, r_d, r_f, r_b0, r_b1, r_d0);
    n_tests++; if (r_d !== 32'hFFFF_CCFF) begin
      n_fail++; $display("FAIL strobe_compare: got %h expected ffffccff", r_d);
    end
  endtask

  task automatic test_random_strobe;
    logic [31:0] d, exp_v;
    logic [3:0]  s;
    wr(A_CTRL, 32'd0, 4'hF, w_f);
    for (int i = 0; i < 6; i++) begin
      d = $urandom;
      s = 4'($urandom_range(0, 15));
      wr(A_PRE, 32'd0, 4'hF, w_f);
      wr(A_PRE, d, s, w_f);
      exp_v = 32'd0;
      for (int b = 0; b < 4; b++) if (s[b]) exp_v[8*b +: 8] = d[8*b +: 8];
      rd(A_PRE, r_d, r_f, r_b0, r_b1, r_d0);
      n_tests++; if (r_d !== exp_v) begin
        n_fail++; $display("FAIL rand_strobe_%0d: got %h expected %h (data %h strb %b)", i, r_d, exp_v, d, s);
      end
    end
  endtask

  // Reference: with prescale P ticks fall every P+1 cycles after enable;
  // the counter cycles 0..C, and one-shot freezes at 0 after the first wrap.
  task automatic test_random_count;
    int p, c, n, k, k2;
    logic os;
    logic [31:0] exp_v;
    for (int it = 0; it < 8; it++) begin
      p  = $urandom_range(0, 3);
      c  = $urandom_range(0, 6);
      n  = $urandom_range(0, 30);
      os = 1'($urandom_range(0, 1));
      wr(A_CTRL, 32'd0, 4'hF, w_f);
      wr(A_STAT, 32'd1, 4'hF, w_f);
      wr(A_VAL,  32'd0, 4'hF, w_f);
      wr(A_PRE,  32'(p), 4'hF, w_f);
      wr(A_CMP,  32'(c), 4'hF, w_f);
      wr(A_CTRL, {29'd0, os, 2'b01}, 4'hF, w_f);
      repeat (n) @(posedge clk);
      #1;
      k  = n / (p + 1);
      k2 = (n + 2) / (p + 1);
      if (os) exp_v = (k >= c + 1) ? 32'd0 : 32'(k);
      else    exp_v = 32'(k % (c + 1));
      rd(A_VAL, r_d, r_f, r_b0, r_b1, r_d0);
      n_tests++; if (r_d !== exp_v) begin
        n_fail++; $display("FAIL rand_value_%0d: got %0d expected %0d (P=%0d C=%0d n=%0d os=%b)", it, r_d, exp_v, p, c, n, os);
      end
      rd(A_STAT, r_d, r_f, r_b0, r_b1, r_d0);
      n_tests++; if (r_d !== {31'd0, (k2 >= c + 1)}) begin
        n_fail++; $display("FAIL rand_match_%0d: got %h expected %0d (P=%0d C=%0d n=%0d)", it, r_d, (k2 >= c + 1), p, c, n);
      end
    end
  endtask

  task automatic test_simultaneous;
    wr(A_CTRL, 32'd0, 4'hF, w_f);
    wr(A_STAT, 32'd1, 4'hF, w_f);
    wr(A_VAL,  32'd0, 4'hF, w_f);
    wr(A_PRE,  32'd0, 4'hF, w_f);
    wr(A_CMP,  32'd0, 4'hF, w_f);
    wr(A_CTRL, 32'd1, 4'hF, w_f);
    wr(A_STAT, 32'd1, 4'hF, w_f);
    rd(A_STAT, r_d, r_f, r_b0, r_b1, r_d0);
    n_tests++; if (r_d !== 32'd1) begin
      n_fail++; $display("FAIL simul_w1c_match: got %h expected 1", r_d);
    end
    wr(A_CMP, 32'd1000, 4'hF, w_f);
    wr(A_VAL, 32'd7, 4'hF, w_f);
    rd(A_VAL, r_d, r_f, r_b0, r_b1, r_d0);
    n_tests++; if (r_d !== 32'd7) begin
      n_fail++; $display("FAIL simul_value_write: got %0d expected 7", r_d);
    end
    wr(A_CTRL, 32'd3, 4'hF, w_f);
  endtask

  task automatic test_reset_mid_read;
    addr = A_CMP; rd_en = 1'b1;
    #1;
    n_tests++; if (busy !== 1'b1) begin
      n_fail++; $display("FAIL midread_busy: got %b expected 1", busy);
    end
    #1 rst_n = 1'b0;
    #1;
    n_tests++; if ({busy, access_fault, interrupt} !== 3'b000 || rd_data !== 32'd0) begin
      n_fail++; $display("FAIL midread_reset_out: got busy=%b fault=%b int=%b data=%h expected all 0", busy, access_fault, interrupt, rd_data);
    end
    @(posedge clk); #1;
    n_tests++; if ({busy, access_fault, interrupt} !== 3'b000 || rd_data !== 32'd0) begin
      n_fail++; $display("FAIL midread_reset_hold: got busy=%b fault=%b int=%b data=%h expected all 0", busy, access_fault, interrupt, rd_data);
    end
    rd_en = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    n_tests++; if (busy !== 1'b0 || access_fault !== 1'b0 || rd_data !== 32'd0) begin
      n_fail++; $display("FAIL midread_no_data: got busy=%b fault=%b data=%h expected 0 0 0", busy, access_fault, rd_data);
    end
    rd(A_CMP, r_d, r_f, r_b0, r_b1, r_d0);
    n_tests++; if (r_b0 !== 1'b1 || r_b1 !== 1'b0 || r_f !== 1'b0 || r_d !== 32'hFFFF_FFFF) begin
      n_fail++; $display("FAIL midread_after: got busy=%b%b fault=%b data=%h expected 10 0 ffffffff", r_b0, r_b1, r_f, r_d);
    end
    rd(A_CTRL, r_d, r_f, r_b0, r_b1, r_d0);
    n_tests++; if (r_d !== 32'd0) begin
      n_fail++; $display("FAIL midread_ctrl: got %h expected 0", r_d);
    end
  endtask

  initial begin
    test_reset;
    test_basic_read;
    test_periodic;
    test_oneshot;
    test_fault_strobe;
    test_random_strobe;
    test_random_count;
    test_simultaneous;
    test_reset_mid_read;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
